// File: rtl/ram_sequencer_if.sv
// Requester-side bundle of the RAM access sequencer: request channel,
// write-data feed and read-data return stream.
interface ram_sequencer_if;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned DATA_W = 32;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_data_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_len, wr_data,
    input  req_ready, wr_data_ready, rd_data, rd_valid, rd_last, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_len, wr_data,
    output req_ready, wr_data_ready, rd_data, rd_valid, rd_last, busy
  );
endinterface

// File: rtl/ram_sequencer.sv
// Turns single/burst read-write requests into one registered RAM access per
// clock for a negedge-sampling 32x32 RAM, and returns captured read words.
module ram_sequencer #(
  localparam int unsigned BURST_MAX = 8,
  localparam int unsigned ADDR_W    = 5,
  localparam int unsigned DATA_W    = 32,
  localparam int unsigned LEN_W     = $clog2(BURST_MAX)
) (
  input  logic              clock,
  input  logic              reset_n,
  ram_sequencer_if.slave    req_if,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_we,
  output logic              ram_chip_select,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d;
  logic              cs_d, ram_we_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_pend_last_q, rd_pend_last_d;
  logic              wdr_c;

  // Next-state and next-pin computation
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    we_d           = we_q;
    addr_d         = ram_address;
    din_d          = ram_data_in;
    cs_d           = ram_chip_select;
    ram_we_d       = ram_we;
    rd_pend_d      = 1'b0;
    rd_pend_last_d = 1'b0;
    wdr_c          = 1'b0;
    unique case (state_q)
      IDLE: begin
        wdr_c = req_if.req_valid && req_if.req_we;
        if (req_if.req_valid) begin
          state_d        = ACCESS;
          we_d           = req_if.req_we;
          cnt_d          = req_if.req_len;
          addr_d         = req_if.req_addr;
          cs_d           = 1'b1;
          ram_we_d       = req_if.req_we;
          if (req_if.req_we) din_d = req_if.wr_data;
          rd_pend_d      = !req_if.req_we;
          rd_pend_last_d = (req_if.req_len == LEN_W'(0));
        end
      end
      ACCESS: begin
        if (cnt_q != LEN_W'(0)) begin
          wdr_c          = we_q;
          addr_d         = ram_address + ADDR_W'(1);
          cnt_d          = cnt_q - LEN_W'(1);
          if (we_q) din_d = req_if.wr_data;
          rd_pend_d      = !we_q;
          rd_pend_last_d = (cnt_q == LEN_W'(1));
        end else begin
          // final beat has had its full cycle on the pins
          cs_d     = 1'b0;
          ram_we_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_if.wr_data_ready = wdr_c;

  // State, RAM pins and read-return registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      we_q             <= 1'b0;
      ram_address      <= '0;
      ram_data_in      <= '0;
      ram_we           <= 1'b0;
      ram_chip_select  <= 1'b0;
      rd_pend_q        <= 1'b0;
      rd_pend_last_q   <= 1'b0;
      req_if.req_ready <= 1'b1;
      req_if.busy      <= 1'b0;
      req_if.rd_data   <= '0;
      req_if.rd_valid  <= 1'b0;
      req_if.rd_last   <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      we_q             <= we_d;
      ram_address      <= addr_d;
      ram_data_in      <= din_d;
      ram_we           <= ram_we_d;
      ram_chip_select  <= cs_d;
      rd_pend_q        <= rd_pend_d;
      rd_pend_last_q   <= rd_pend_last_d;
      req_if.req_ready <= (state_d == IDLE);
      req_if.busy      <= (state_d == ACCESS);
      // only sample the RAM output after a read beat; it is undriven otherwise
      if (rd_pend_q) begin
        req_if.rd_data  <= ram_data_out;
        req_if.rd_valid <= 1'b1;
        req_if.rd_last  <= rd_pend_last_q;
      end else begin
        req_if.rd_valid <= 1'b0;
        req_if.rd_last  <= 1'b0;
      end
    end
  end

endmodule
